// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage ahead of decode.
// Owns the PC, reads a single-cycle-latency program memory and buffers
// {instruction, pc} pairs in a DEPTH-entry FIFO. Decode pops the FIFO over
// a valid/ready handshake. A redirect flushes buffered and in-flight
// fetches and restarts from the new PC in the same cycle.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   redirect       flush and restart fetch at redirect_pc
//   redirect_pc    new PC (bits [1:0] ignored)
//   halt           stop issuing new fetches; FIFO keeps draining
//   imem_rd        program memory read strobe
//   imem_addr      program memory word address
//   imem_q         read data, valid the cycle after imem_rd
//   id_valid       head entry valid towards decode
//   id_ready       decode accepts head entry
//   id_instruction head instruction (0 when id_valid is low)
//   id_pc          PC of head instruction (0 when id_valid is low)
//   id_pc_plus4    id_pc + 4, wrapping (0 when id_valid is low)
//   count          FIFO occupancy
//
// Build option: define FETCHQ_BYPASS_EN to let a response arriving at an
// empty FIFO drive id_* in the same cycle instead of taking a FIFO slot.

module fetch_queue #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int IMEM_AW    = 6,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    input  logic                      halt,
    output logic                      imem_rd,
    output logic [IMEM_AW-1:0]        imem_addr,
    input  logic [BIT_WIDTH-1:0]      imem_q,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [BIT_WIDTH-1:0]      id_instruction,
    output logic [ADDR_WIDTH-1:0]     id_pc,
    output logic [ADDR_WIDTH-1:0]     id_pc_plus4,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic                  inflight;
    logic                  kill;

    logic [BIT_WIDTH-1:0]  mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    logic [OW-1:0]         occupancy;
    logic                  room;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  capture;
    logic                  push;
    logic                  issue;

    logic                  head_valid;
    logic [BIT_WIDTH-1:0]  head_instr;
    logic [ADDR_WIDTH-1:0] head_pc;

    // ---------------------------------------------------------------
    // Fetch address: a redirect steers this cycle's read straight to
    // the target so the restart costs no bubble.
    // ---------------------------------------------------------------
    assign target    = redirect_pc & ALIGN;
    assign fetch_pc  = redirect ? target : pc;
    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    // Slots already promised: buffered entries plus the one in flight.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign room       = occupancy < OW'(DEPTH);
    assign fifo_empty = (count == '0);
    assign fifo_pop   = id_ready && !fifo_empty;

    // The response landing in a redirect cycle belongs to the old
    // stream and is dropped.
    assign capture = inflight && !kill && !redirect;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (halt && !redirect) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (redirect || !halt) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs. A redirect frees every slot at the end of the
    // cycle, so it never has to wait for room.
    // ---------------------------------------------------------------
    always_comb begin
        issue = 1'b0;
        if (state == RUN && !halt) begin
            issue = redirect || room || fifo_pop;
        end
    end

    assign imem_rd = issue;

    // ---------------------------------------------------------------
    // PC and in-flight tracking
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            kill     <= 1'b0;
            resp_pc  <= '0;
        end else begin
            inflight <= issue;
            // A redirect with no fresh issue leaves no valid response
            // behind it.
            kill     <= redirect && !issue;
            if (issue) begin
                resp_pc <= fetch_pc;
            end
            if (redirect) begin
                pc <= issue ? target + STEP : target;
            end else if (issue) begin
                pc <= pc + STEP;
            end
        end
    end

    // ---------------------------------------------------------------
    // Head selection and push control
    // ---------------------------------------------------------------
`ifdef FETCHQ_BYPASS_EN
    logic bypass;

    assign bypass     = capture && fifo_empty;
    assign push       = capture && !(bypass && id_ready);
    assign head_valid = !fifo_empty || bypass;
    assign head_instr = bypass ? imem_q  : mem_instr[rd_ptr];
    assign head_pc    = bypass ? resp_pc : mem_pc[rd_ptr];
`else
    assign push       = capture;
    assign head_valid = !fifo_empty;
    assign head_instr = mem_instr[rd_ptr];
    assign head_pc    = mem_pc[rd_ptr];
`endif

    // ---------------------------------------------------------------
    // FIFO pointers and occupancy
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(fifo_pop);
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_q;
            mem_pc[wr_ptr]    <= resp_pc;
        end
    end

    // ---------------------------------------------------------------
    // Decode-side outputs, forced to zero while nothing is valid
    // ---------------------------------------------------------------
    assign id_valid       = head_valid;
    assign id_instruction = head_valid ? head_instr : '0;
    assign id_pc          = head_valid ? head_pc : '0;
    assign id_pc_plus4    = head_valid ? head_pc + STEP : '0;

    // Issue throttling guarantees a push never lands on a full FIFO.
    assert property (@(posedge clk) disable iff (!rst)
        !(push && !fifo_pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (default build).
// Program memory word i holds 0xF000_0000 | i.

module tb_fetch_queue;

    localparam int BW  = 32;
    localparam int AW  = 32;
    localparam int IAW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           redirect = 1'b0;
    logic [AW-1:0]  redirect_pc = '0;
    logic           halt = 1'b0;
    logic           imem_rd;
    logic [IAW-1:0] imem_addr;
    logic [BW-1:0]  imem_q = '0;
    logic           id_valid;
    logic           id_ready = 1'b0;
    logic [BW-1:0]  id_instruction;
    logic [AW-1:0]  id_pc;
    logic [AW-1:0]  id_pc_plus4;
    logic [2:0]     count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [5:0] a);
        return 32'hF000_0000 | {26'd0, a};
    endfunction

    // Single-cycle-latency program memory
    always @(posedge clk) begin
        if (imem_rd) imem_q <= word(imem_addr);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge starting cycle 0 (BOOT).
    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        halt = 1'b0;
        id_ready = 1'b0;
        cyc(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(2);
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", imem_rd); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (id_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", id_instruction); end
        n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", id_pc); end
        n_checks++; if (id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", id_pc_plus4); end
    endtask

    task automatic test_startup();
        do_reset();
        id_ready = 1'b1;
        #1;
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL boot_rd: got %b want 0", imem_rd); end
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            if (k == 1) begin
                n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 6'd0) begin n_fail++; $display("FAIL first_issue: rd %b addr %0d want 1/0", imem_rd, imem_addr); end
            end
            if (k < 3) begin
                n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL startup_early k=%0d: valid %b want 0", k, id_valid); end
            end else begin
                n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * (k - 3))) begin n_fail++; $display("FAIL startup_pc k=%0d: valid %b pc %h want 1/%h", k, id_valid, id_pc, 32'(4 * (k - 3))); end
                n_checks++; if (id_instruction !== word(6'(k - 3))) begin n_fail++; $display("FAIL startup_instr k=%0d: got %h want %h", k, id_instruction, word(6'(k - 3))); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cyc(12);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", count); end
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rd: got %b want 0", imem_rd); end
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: valid %b pc %h want 1/0", id_valid, id_pc); end
        id_ready = 1'b1;
        #1;
        n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 6'd4) begin n_fail++; $display("FAIL bp_resume_issue: rd %b addr %0d want 1/4", imem_rd, imem_addr); end
        for (int j = 1; j <= 5; j++) begin
            cyc(1);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * j)) begin n_fail++; $display("FAIL bp_seq j=%0d: valid %b pc %h want 1/%h", j, id_valid, id_pc, 32'(4 * j)); end
            n_checks++; if (id_instruction !== word(6'(j))) begin n_fail++; $display("FAIL bp_instr j=%0d: got %h want %h", j, id_instruction, word(6'(j))); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(8);
        rst = 1'b0;
        cyc(1);
        n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: count %0d valid %b want 0/0", count, id_valid); end
        rst = 1'b1;
        id_ready = 1'b1;
        cyc(2);
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early: valid %b want 0", id_valid); end
        cyc(1);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_first: valid %b pc %h want 1/0", id_valid, id_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        cyc(5);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count: got %0d want 3", count); end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 6'd16) begin n_fail++; $display("FAIL redir_issue: rd %b addr %0d want 1/16", imem_rd, imem_addr); end
        cyc(1);
        redirect = 1'b0;
        n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: count %0d valid %b want 0/0", count, id_valid); end
        cyc(1);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin n_fail++; $display("FAIL redir_target: valid %b pc %h want 1/40", id_valid, id_pc); end
        n_checks++; if (id_instruction !== word(6'd16)) begin n_fail++; $display("FAIL redir_instr: got %h want %h", id_instruction, word(6'd16)); end
        id_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cyc(1);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'(32'h40 + 4 * j)) begin n_fail++; $display("FAIL redir_seq j=%0d: valid %b pc %h want 1/%h", j, id_valid, id_pc, 32'(32'h40 + 4 * j)); end
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        id_ready = 1'b1;
        cyc(5);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin n_fail++; $display("FAIL rp_head: valid %b pc %h want 1/8", id_valid, id_pc); end
        redirect = 1'b1;
        redirect_pc = 32'h43;
        #1;
        n_checks++; if (imem_addr !== 6'd16) begin n_fail++; $display("FAIL rp_align_addr: got %0d want 16", imem_addr); end
        cyc(1);
        redirect = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rp_flush: valid %b count %0d want 0/0", id_valid, count); end
        cyc(1);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin n_fail++; $display("FAIL rp_target: valid %b pc %h want 1/40", id_valid, id_pc); end
        n_checks++; if (id_pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL rp_pc4: got %h want 44", id_pc_plus4); end
        cyc(1);
        n_checks++; if (id_pc !== 32'h44) begin n_fail++; $display("FAIL rp_next: got %h want 44", id_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        id_ready = 1'b1;
        cyc(4);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc(1);
        redirect = 1'b0;
        cyc(1);
        n_checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_top: pc %h pc4 %h want fffffffc/0", id_pc, id_pc_plus4); end
        n_checks++; if (id_instruction !== word(6'd63)) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", id_instruction, word(6'd63)); end
        cyc(1);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL wrap_next: valid %b pc %h pc4 %h want 1/0/4", id_valid, id_pc, id_pc_plus4); end
    endtask

    task automatic test_halt();
        int w;
        do_reset();
        id_ready = 1'b1;
        cyc(5);
        n_checks++; if (id_pc !== 32'h8) begin n_fail++; $display("FAIL halt_pre: got %h want 8", id_pc); end
        halt = 1'b1;
        #1;
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_rd0: got %b want 0", imem_rd); end
        for (int k = 6; k <= 9; k++) begin
            cyc(1);
            n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_rd k=%0d: got %b want 0", k, imem_rd); end
            if (k == 6) begin
                n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC) begin n_fail++; $display("FAIL halt_drain: valid %b pc %h want 1/c", id_valid, id_pc); end
            end
            if (k >= 7) begin
                n_checks++; if (id_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL halt_empty k=%0d: valid %b count %0d want 0/0", k, id_valid, count); end
            end
        end
        cyc(1);
        halt = 1'b0;
        #1;
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_exit_rd: got %b want 0", imem_rd); end
        w = 0;
        while (!id_valid && w < 8) begin
            cyc(1);
            w++;
        end
        n_checks++; if (w !== 3) begin n_fail++; $display("FAIL halt_resume_lat: got %0d cycles want 3", w); end
        n_checks++; if (id_pc !== 32'h10) begin n_fail++; $display("FAIL halt_resume_pc: got %h want 10", id_pc); end
        cyc(1);
        n_checks++; if (id_pc !== 32'h14) begin n_fail++; $display("FAIL halt_resume_next: got %h want 14", id_pc); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_mid_reset();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
